// File: rtl/sseg_disp_mux_pkg.sv
// Shared constants and state encoding for the multiplexed seven-segment driver.
package sseg_disp_mux_pkg;

  localparam logic [6:0] SSEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/mod_m_counter.sv
// Modulo-M counter with a synchronous clear (en low) and a wrap pulse.
module mod_m_counter #(
  parameter int M = 50000,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [N-1:0] q,
  output logic         max_tick
);

  localparam logic [N-1:0] LAST = N'(M - 1);

  // Holding en low parks the count at zero so a restart begins a fresh slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (!en) begin
      q <= '0;
    end else if (q == LAST) begin
      q <= '0;
    end else begin
      q <= q + N'(1);
    end
  end

  assign max_tick = en && (q == LAST);

endmodule

// File: rtl/sseg_disp_mux.sv
// Four-digit time-multiplexed seven-segment driver with a blanking guard per
// slot and a once-per-frame capture of the digit inputs.
module sseg_disp_mux
  import sseg_disp_mux_pkg::*;
#(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CW           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  input  logic [6:0] hex2,
  input  logic [6:0] hex3,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [6:0] sseg,
  output logic       dp,
  output logic       frame_tick
);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0]   cnt;
  logic            slot_end;
  logic [1:0]      idx;
  state_t          state;
  logic [3:0][6:0] shadow_hex;
  logic [3:0]      shadow_dp;
  logic            frame_start;

  mod_m_counter #(
    .M (SLOT_CYCLES),
    .N (CW)
  ) u_slot_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .q        (cnt),
    .max_tick (slot_end)
  );

  assign frame_start = en && (cnt == '0) && (idx == 2'd0);

  // State tracks the counter (DRIVE iff count >= BLANK_CYCLES); the outputs
  // are produced from the current state, so they trail it by one cycle and
  // the last DRIVE cycle of a slot still shows the old digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= 2'd0;
      state      <= BLANK;
      shadow_hex <= {4{SSEG_BLANK}};
      shadow_dp  <= 4'b1111;
      an         <= AN_OFF;
      sseg       <= SSEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) begin
        shadow_hex <= {hex3, hex2, hex1, hex0};
        shadow_dp  <= dp_in;
      end

      if (!en) begin
        idx <= 2'd0;
      end else if (slot_end) begin
        idx <= idx + 2'd1;
      end

      if (!en || slot_end) begin
        state <= BLANK;
      end else if (cnt == BLANK_LAST) begin
        state <= DRIVE;
      end

      if (!en || state == BLANK) begin
        an   <= AN_OFF;
        sseg <= SSEG_BLANK;
        dp   <= 1'b1;
      end else begin
        an   <= ~(4'b0001 << idx);
        sseg <= shadow_hex[idx];
        dp   <= shadow_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_sseg_disp_mux.sv
// Self-checking bench for sseg_disp_mux with 8-cycle slots and 2 blank cycles.
module tb_sseg_disp_mux;
  import sseg_disp_mux_pkg::*;

  localparam int SLOT  = 8;
  localparam int BLNK  = 2;
  localparam int FRAME = 4 * SLOT;

  logic       clk;
  logic       reset;
  logic       en;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       dp;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  int j = -1;
  logic [6:0] sh_hex [4];
  logic [3:0] sh_dp;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
    logic       ft;
  } vec_t;

  vec_t vecs [13];

  sseg_disp_mux #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLNK),
    .CW           (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .dp_in      (dp_in),
    .an         (an),
    .sseg       (sseg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at j=%0d", j);
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic e, input logic [6:0] h0, input logic [6:0] h1,
                               input logic [6:0] h2, input logic [6:0] h3, input logic [3:0] d);
    en = e; hex0 = h0; hex1 = h1; hex2 = h2; hex3 = h3; dp_in = d;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] ea, input logic [6:0] es,
                             input logic ed, input logic ef);
    checks++;
    if (an !== ea || sseg !== es || dp !== ed || frame_tick !== ef) begin
      errors++;
      $display("[TB] FAIL %s j=%0d an=%b want %b sseg=%h want %h dp=%b want %b ft=%b want %b",
               name, j, an, ea, sseg, es, dp, ed, frame_tick, ef);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s j=%0d got %0d want %0d", name, j, actual, required);
    end
  endtask

  // Advance one clock; capture the model shadow on frame-start edges.
  task automatic tick();
    @(posedge clk);
    j++;
    if (j % FRAME == 0) begin
      sh_hex[0] = hex0; sh_hex[1] = hex1; sh_hex[2] = hex2; sh_hex[3] = hex3;
      sh_dp = dp_in;
    end
    @(negedge clk);
  endtask

  task automatic checkModel(input string name);
    int pos, d, c;
    logic [3:0] ea;
    logic [6:0] es;
    logic ed;
    pos = j % FRAME;
    d = pos / SLOT;
    c = pos % SLOT;
    ea = AN_OFF; es = SSEG_BLANK; ed = 1'b1;
    if (c >= BLNK) begin
      ea[d] = 1'b0;
      es = sh_hex[d];
      ed = sh_dp[d];
    end
    checkOutput(name, ea, es, ed, pos == 0);
  endtask

  task automatic tickChecked(input string name);
    tick();
    checkModel(name);
  endtask

  initial begin
    int last_ft;
    int low_cnt [4];

    vecs[0]  = '{0,  4'b1111, 7'h7F, 1'b1, 1'b1};
    vecs[1]  = '{1,  4'b1111, 7'h7F, 1'b1, 1'b0};
    vecs[2]  = '{2,  4'b1110, 7'h40, 1'b0, 1'b0};
    vecs[3]  = '{7,  4'b1110, 7'h40, 1'b0, 1'b0};
    vecs[4]  = '{8,  4'b1111, 7'h7F, 1'b1, 1'b0};
    vecs[5]  = '{9,  4'b1111, 7'h7F, 1'b1, 1'b0};
    vecs[6]  = '{10, 4'b1101, 7'h79, 1'b1, 1'b0};
    vecs[7]  = '{15, 4'b1101, 7'h79, 1'b1, 1'b0};
    vecs[8]  = '{18, 4'b1011, 7'h24, 1'b1, 1'b0};
    vecs[9]  = '{26, 4'b0111, 7'h30, 1'b1, 1'b0};
    vecs[10] = '{31, 4'b0111, 7'h30, 1'b1, 1'b0};
    vecs[11] = '{32, 4'b1111, 7'h7F, 1'b1, 1'b1};
    vecs[12] = '{34, 4'b1110, 7'h40, 1'b0, 1'b0};

    // Reset state, then the basic scan sequence.
    reset = 1'b1;
    applyStimulus(1'b1, 7'h40, 7'h79, 7'h24, 7'h30, 4'b1110);
    repeat (3) @(negedge clk);
    checkOutput("reset_state", AN_OFF, SSEG_BLANK, 1'b1, 1'b0);
    reset = 1'b0;
    j = -1;
    for (int i = 0; i < 13; i++) begin
      while (j < vecs[i].cyc) tick();
      checkOutput("scan_table", vecs[i].an, vecs[i].sseg, vecs[i].dp, vecs[i].ft);
    end

    // Mid-frame input change stays invisible until the next frame.
    while (j < 42) tickChecked("pre_change");
    applyStimulus(1'b1, 7'h40, 7'h79, 7'h12, 7'h30, 4'b1110);
    while (j < 50) tick();
    checkOutput("old_hex2_this_frame", 4'b1011, 7'h24, 1'b1, 1'b0);
    while (j < 82) tickChecked("frame_capture");
    checkOutput("new_hex2_next_frame", 4'b1011, 7'h12, 1'b1, 1'b0);

    // Asynchronous reset in the middle of digit 2's drive window.
    while (j < 84) tickChecked("pre_reset");
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", AN_OFF, SSEG_BLANK, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    j = -1;
    repeat (34) tickChecked("after_reset");

    // Enable held low for 20 cycles, then raised.
    applyStimulus(1'b0, 7'h40, 7'h79, 7'h12, 7'h30, 4'b1110);
    repeat (20) begin
      tick();
      checkOutput("en_low_dark", AN_OFF, SSEG_BLANK, 1'b1, 1'b0);
    end
    en = 1'b1;
    j = -1;
    tick();
    checkOutput("en_rise_tick", AN_OFF, SSEG_BLANK, 1'b1, 1'b1);
    tick();
    checkOutput("en_rise_blank", AN_OFF, SSEG_BLANK, 1'b1, 1'b0);
    tick();
    checkOutput("en_rise_drive", 4'b1110, 7'h40, 1'b0, 1'b0);

    // Random inputs over ten full frames with duty and period bookkeeping.
    last_ft = 0;
    for (int b = 0; b < 4; b++) low_cnt[b] = 0;
    while (j < 11 * FRAME - 1) begin
      tickChecked("random_model");
      if (j >= FRAME) begin
        if (j % FRAME == 0) for (int b = 0; b < 4; b++) low_cnt[b] = 0;
        for (int b = 0; b < 4; b++) if (an[b] == 1'b0) low_cnt[b]++;
        checkValue("an_onehot_low", ($countones(~an) <= 1) ? 1 : 0, 1);
        if (frame_tick) begin
          checkValue("frame_period", j - last_ft, FRAME);
          last_ft = j;
        end
        if (j % FRAME == FRAME - 1)
          for (int b = 0; b < 4; b++) checkValue("an_duty", low_cnt[b], SLOT - BLNK);
      end
      if ($urandom_range(0, 3) == 0)
        applyStimulus(1'b1, 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 4'($urandom));
    end

    // One-cycle enable drop during digit 3 restarts at digit 0.
    while (j % FRAME != 28) tickChecked("pre_drop");
    applyStimulus(1'b0, 7'h08, 7'h03, 7'h46, 7'h21, 4'b0111);
    tick();
    checkOutput("drop_blank", AN_OFF, SSEG_BLANK, 1'b1, 1'b0);
    en = 1'b1;
    j = -1;
    tick();
    checkOutput("restart_tick", AN_OFF, SSEG_BLANK, 1'b1, 1'b1);
    tick();
    checkOutput("restart_blank", AN_OFF, SSEG_BLANK, 1'b1, 1'b0);
    tick();
    checkOutput("restart_digit0", 4'b1110, 7'h08, 1'b1, 1'b0);
    while (j < 40) tickChecked("restart_model");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
